// File: rtl/tree_spawn_scheduler.sv
// tree_spawn_scheduler
//   Once-per-frame sequencer for the tree obstacle pool. It decides when a
//   new tree is spawned, which free slot receives it (round-robin), and the
//   random start column. It also parks slots that were hit or left the
//   playfield.
//
// Ports:
//   clk, resetN     system clock, synchronous active-low reset
//   startOfFrame    one-cycle pulse per video frame
//   enable          game running; low freezes spawning (state -> IDLE)
//   random[7:0]     free-running random value
//   collision[N]    per-slot hit pulse
//   offscreen[N]    per-slot "left playfield" level
//   deploy[N]       one-hot, one-cycle spawn pulse
//   remove[N]       one-cycle park pulse per slot
//   initial_x[10:0] spawn column of the most recently deployed slot
//   speed[1:0]      shared scroll speed
//   active[N]       slot-occupied flags
//
// Configuration macro: TREE_SPEEDUP_EN
//   Defined: speed increments every SPAWNS_PER_LEVEL deploys, saturating
//   at 3. Undefined: speed is fixed at SPEED_INIT.
module tree_spawn_scheduler #(
    parameter int NUM_TREES        = 4,
    parameter int MIN_GAP          = 20,
    parameter int X_MIN            = 64,
    parameter int SPAWNS_PER_LEVEL = 8,
    parameter int SPEED_INIT       = 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic [7:0]           random,
    input  logic [NUM_TREES-1:0] collision,
    input  logic [NUM_TREES-1:0] offscreen,
    output logic [NUM_TREES-1:0] deploy,
    output logic [NUM_TREES-1:0] remove,
    output logic [10:0]          initial_x,
    output logic [1:0]           speed,
    output logic [NUM_TREES-1:0] active
);

    localparam int PW = $clog2(NUM_TREES);
    localparam logic [NUM_TREES-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, WAIT, SPAWN, FULL} state_t;

    state_t               state;
    logic [5:0]           gap;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        pick;
    logic                 found;
    int                   j;
    logic                 any_free;
    logic                 gap_hit;
    logic [5:0]           gap_dec;
    logic [NUM_TREES-1:0] hit;
    logic [NUM_TREES-1:0] spawn_bits;

    // Round-robin search for a free slot, starting at ptr. Uses the
    // registered active flags, so a slot freed this cycle is seen next cycle.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < NUM_TREES; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_TREES) j = j - NUM_TREES;
            if (!found && !active[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    assign any_free = ~&active;
    assign gap_dec  = (gap == 6'd0) ? 6'd0 : gap - 6'd1;
    // The gap is considered expired either when it already sits at 0 or
    // when this frame's decrement brings it there.
    assign gap_hit  = startOfFrame ? (gap <= 6'd1) : (gap == 6'd0);
    // Hits only matter on occupied slots; this also makes a held offscreen
    // level produce a single remove pulse.
    assign hit      = active & (collision | offscreen);
    assign spawn_bits = (state == SPAWN && enable && found) ? (ONE << pick) : '0;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            gap       <= 6'(MIN_GAP);
            ptr       <= '0;
            deploy    <= '0;
            remove    <= '0;
            active    <= '0;
            initial_x <= 11'(X_MIN);
        end else begin
            deploy <= spawn_bits;
            remove <= hit;
            // The chosen slot is inactive, so deploy and remove never overlap.
            active <= (active & ~hit) | spawn_bits;
            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= WAIT;
                    WAIT: begin
                        if (startOfFrame) gap <= gap_dec;
                        if (gap_hit) state <= any_free ? SPAWN : FULL;
                    end
                    FULL: if (any_free) state <= SPAWN;
                    SPAWN: begin
                        if (found) begin
                            initial_x <= 11'(X_MIN) + {2'b00, random, 1'b0};
                            ptr       <= (pick == PW'(NUM_TREES - 1)) ? '0 : pick + 1'b1;
                        end
                        gap   <= 6'(MIN_GAP) + {2'b00, random[3:0]};
                        state <= WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TREE_SPEEDUP_EN
    localparam int CW = (SPAWNS_PER_LEVEL > 1) ? $clog2(SPAWNS_PER_LEVEL) : 1;
    logic [CW-1:0] spawn_cnt;

    // Counts visible deploy pulses, so speed changes one cycle after one.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            spawn_cnt <= '0;
            speed     <= 2'(SPEED_INIT);
        end else if (|deploy) begin
            if (spawn_cnt == CW'(SPAWNS_PER_LEVEL - 1)) begin
                spawn_cnt <= '0;
                if (speed != 2'd3) speed <= speed + 2'd1;
            end else begin
                spawn_cnt <= spawn_cnt + 1'b1;
            end
        end
    end
`else
    assign speed = 2'(SPEED_INIT);
`endif

endmodule
